// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between inst fetch and data load/store
// One transaction outstanding; data wins by default, a starvation counter forces inst through.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_mem
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state;
  logic              owner;  // 1 = data requester owns the transaction
  logic [CW-1:0]     starve_cnt;
  logic              wr_q;
  logic [SW-1:0]     wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic grant_inst;
  logic in_addr;
  logic in_data;
  logic addr_done;
  logic data_done;

  // inst only wins when it actually asks, so a saturated counter never grants an empty slot
  assign grant_inst = inst_req && ((starve_cnt == CNT_MAX) || !data_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      wr_q       <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            state <= ADDR;
            owner <= !grant_inst;
            if (grant_inst) begin
              wr_q       <= inst_wr;
              wstrb_q    <= inst_wstrb;
              addr_q     <= inst_addr;
              wdata_q    <= inst_wdata;
              starve_cnt <= '0;
            end else begin
              wr_q    <= data_wr;
              wstrb_q <= data_wstrb;
              addr_q  <= data_addr;
              wdata_q <= data_wdata;
              if (inst_req && (starve_cnt != CNT_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ADDR:    if (mem_addr_ok) state <= DATA;
        DATA:    if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_addr   = (state == ADDR);
  assign in_data   = (state == DATA);
  assign addr_done = in_addr && mem_addr_ok;
  assign data_done = in_data && mem_data_ok;

  assign mem_req   = in_addr;
  assign mem_wr    = in_addr && wr_q;
  assign mem_wstrb = in_addr ? wstrb_q : '0;
  assign mem_addr  = in_addr ? addr_q : '0;
  assign mem_wdata = in_addr ? wdata_q : '0;

  assign inst_addr_ok = addr_done && !owner;
  assign data_addr_ok = addr_done && owner;
  assign inst_data_ok = data_done && !owner;
  assign data_data_ok = data_done && owner;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign stallreq_mem = !rst && (((state == IDLE) && (inst_req || data_req)) || in_addr
                                 || (in_data && !mem_data_ok));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed vector bench for sram_port_arbiter
// Cycle table for the basic flows, hand sequences for starvation, wait states and reset.
module tb_sram_port_arbiter;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;
  localparam logic [31:0] WD = 32'h0000_1234;
  localparam logic [31:0] R1 = 32'h3C01_0001;
  localparam logic [31:0] R2 = 32'h2402_00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic        inst_wr = 1'b0, data_wr = 1'b1;
  logic [3:0]  inst_wstrb = 4'h0, data_wstrb = 4'hF;
  logic [31:0] inst_addr = IA, data_addr = DA;
  logic [31:0] inst_wdata = 32'h0, data_wdata = WD;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem)
  );

  typedef struct {
    bit           r, ir, dr, ao, dk;
    logic [31:0]  rd;
    logic [134:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit ir, input bit dr, input bit ao,
                              input bit dk, input logic [31:0] rd,
                              input bit mreq, input bit mwr, input logic [31:0] maddr,
                              input logic [31:0] mwd, input bit iao, input bit ido,
                              input logic [31:0] ird, input bit dao, input bit ddo,
                              input logic [31:0] drd, input bit st);
    vec_t v;
    v.r = r; v.ir = ir; v.dr = dr; v.ao = ao; v.dk = dk; v.rd = rd;
    v.exp = {mreq, mwr, maddr, mwd, iao, ido, ird, dao, ddo, drd, st};
    return v;
  endfunction

  function automatic logic [134:0] outs();
    return {mem_req, mem_wr, mem_addr, mem_wdata, inst_addr_ok, inst_data_ok, inst_rdata,
            data_addr_ok, data_data_ok, data_rdata, stallreq_mem};
  endfunction

  task automatic chk(input string name, input logic [134:0] got, input logic [134:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int grants[$];
  int iao_cnt, ido_cnt;

  initial begin
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

    tbl.push_back(mk(1,0,0,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  0));
    // single inst read, addr_ok in cycle 2, data_ok in cycle 4, then stray pulses in IDLE
    tbl.push_back(mk(0,1,0,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,1,0,0,0,0,     1,0,IA,0,  0,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,1,0,1,0,0,     1,0,IA,0,  1,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,0,0,0,1,R1,    0,0,0,0,   0,1,R1, 0,0,0,  0));
    tbl.push_back(mk(0,0,0,1,1,32'h55,0,0,0,0,   0,0,0,  0,0,0,  0));
    tbl.push_back(mk(0,0,0,1,0,0,     0,0,0,0,   0,0,0,  0,0,0,  0));
    tbl.push_back(mk(0,0,0,0,1,32'h66,0,0,0,0,   0,0,0,  0,0,0,  0));
    // collision: data write first (addr_ok and data_ok together in ADDR), then inst
    tbl.push_back(mk(0,1,1,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,1,1,1,1,32'hAA,1,1,DA,WD, 0,0,0,  1,0,0,  1));
    tbl.push_back(mk(0,1,0,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,1,0,0,1,32'h77,0,0,0,0,   0,0,0,  0,1,32'h77, 0));
    tbl.push_back(mk(0,1,0,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,1,0,1,0,0,     1,0,IA,0,  1,0,0,  0,0,0,  1));
    tbl.push_back(mk(0,0,0,0,1,R2,    0,0,0,0,   0,1,R2, 0,0,0,  0));
    tbl.push_back(mk(0,0,0,0,0,0,     0,0,0,0,   0,0,0,  0,0,0,  0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; inst_req = tbl[i].ir; data_req = tbl[i].dr;
      mem_addr_ok = tbl[i].ao; mem_data_ok = tbl[i].dk; mem_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      tick();
    end

    // starvation: both held, downstream always ready -> D,D,D,D,I
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = '0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (data_addr_ok) grants.push_back(0);
      if (inst_addr_ok) grants.push_back(1);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk("starve_grant_count", 135'(grants.size()), 135'(5));
    for (int g = 0; g < 5 && g < grants.size(); g++)
      chk($sformatf("starve_grant%0d", g), 135'(grants[g]), 135'(g == 4 ? 1 : 0));
    @(negedge clk);
    chk("starve_cnt_cleared", 135'(dut.starve_cnt), 135'(0));
    tick();

    // wait states: addr_ok after 5 idle ADDR cycles, data_ok after 7 idle DATA cycles
    iao_cnt = 0; ido_cnt = 0;
    inst_req = 1'b1; mem_rdata = R1;
    @(negedge clk);
    chk("wait_idle_stall", 135'(stallreq_mem), 135'(1));
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iao_cnt += int'(inst_addr_ok); ido_cnt += int'(inst_data_ok);
      chk($sformatf("wait_addr%0d", k), {mem_req, mem_addr, stallreq_mem}, {1'b1, IA, 1'b1});
      tick();
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    iao_cnt += int'(inst_addr_ok); ido_cnt += int'(inst_data_ok);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      iao_cnt += int'(inst_addr_ok); ido_cnt += int'(inst_data_ok);
      chk($sformatf("wait_data%0d", k), {mem_req, stallreq_mem}, 135'b01);
      tick();
    end
    mem_data_ok = 1'b1;
    @(negedge clk);
    iao_cnt += int'(inst_addr_ok); ido_cnt += int'(inst_data_ok);
    chk("wait_rdata", 135'(inst_rdata), 135'(R1));
    tick();
    mem_data_ok = 1'b0;
    chk("wait_addr_ok_pulses", 135'(iao_cnt), 135'(1));
    chk("wait_data_ok_pulses", 135'(ido_cnt), 135'(1));

    // reset while in DATA, then a stray data_ok two cycles later
    inst_req = 1'b1;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("rst_pre_in_data", 135'(stallreq_mem), 135'(1));
    tick();
    rst = 1'b1;
    #1;
    chk("rst_outputs_zero", outs(), '0);
    tick();
    rst = 1'b0;
    tick();
    mem_data_ok = 1'b1; mem_rdata = R2;
    @(negedge clk);
    chk("rst_stray_data_ok", outs(), '0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("rst_still_idle", 135'(dut.state), 135'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
